mul_acc_seq: RTL and testbench
==============================

MUL_ACC_SEQ -- requirements
Module: mul_acc_seq

Interface
REQ-001 SHALL have parameter CP_D_WIDTH, default 72, the datapath width of the sequenced multiply-accumulate unit; it is carried through only, with no internal logic.
REQ-002 SHALL have parameter LIMBS, default 4, the limbs per operation (legal range 2..2^IDX_W-1).
REQ-003 SHALL have parameter LAT, default 6, the MAC core pipeline latency (legal range >=1).
REQ-004 SHALL have parameter IDX_W, default 4, the width of the limb index.
REQ-005 SHALL have port clock, input, 1 bit: the only clock, rising edge.
REQ-006 SHALL have port nreset, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit: request one row operation R = A*b + C.
REQ-008 SHALL have port stall, input, 1 bit: freeze request (present only with the Configuration macro).
REQ-009 SHALL have port MulAccEn, output, 1 bit: MAC pipeline and carry enable.
REQ-010 SHALL have port ArithOp, output, 1 bit: add the stored carry into the current output.
REQ-011 SHALL have port ArithRegOp, output, 1 bit: hold the MAC carry registers.
REQ-012 SHALL have port rd_idx, output, IDX_W bits: limb index for the A/C operand reads.
REQ-013 SHALL have port wr_en, output, 1 bit: result write strobe.
REQ-014 SHALL have port wr_idx, output, IDX_W bits: result limb index.
REQ-015 SHALL have port wr_carry_sel, output, 1 bit: write data is the MAC carry, not the MAC output.
REQ-016 SHALL have port busy, output, 1 bit: operation in progress.
REQ-017 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, ISSUE, DRAIN and CARRY, with fixed transitions: IDLE->ISSUE on start=1; ISSUE->DRAIN after LIMBS cycles; DRAIN->CARRY after LAT cycles; CARRY->IDLE after 1 cycle.
REQ-019 SHALL ignore start outside IDLE, with no queuing.
REQ-020 In ISSUE, SHALL assert MulAccEn=1 and drive rd_idx from 0 to LIMBS-1, incrementing by one each cycle.
REQ-021 In DRAIN, SHALL assert MulAccEn=1 and hold rd_idx=0.
REQ-022 In IDLE and CARRY, SHALL drive MulAccEn=0.
REQ-023 SHALL carry a LAT-deep tag shift register {valid, first}, advanced only on cycles where MulAccEn=1.
REQ-024 SHALL load the tag as {1, rd_idx==0} during ISSUE and as {0, 0} otherwise.
REQ-025 SHALL derive the following from the tag at the shift-register output: ArithRegOp = MulAccEn & ~valid; ArithOp = valid & ~first; wr_en = MulAccEn & valid; wr_idx = a counter of emerged valid slots, starting at 0.
REQ-026 SHALL raise the first write to result limb 0 with ArithOp=0, so no stale carry is added; every later limb SHALL have ArithOp=1.
REQ-027 In CARRY, SHALL assert wr_en=1, wr_idx=LIMBS, wr_carry_sel=1 and done=1; wr_carry_sel and done SHALL be 0 in all other cycles.
REQ-028 SHALL drive busy=1 in ISSUE, DRAIN and CARRY, and busy=0 in IDLE.
REQ-029 SHALL accept start=1 during the CARRY cycle only at the following IDLE cycle, giving a minimum of 1 idle cycle between operations.
REQ-030 SHALL use only wrap-free counters: the issue counter stops at LIMBS-1, the drain counter at LAT-1, and wr_idx never exceeds LIMBS.

Reset
REQ-031 On nreset=0, SHALL immediately enter IDLE and clear all counters and tags.
REQ-032 On nreset=0, SHALL drive every output to 0.
REQ-033 SHALL make an operation interrupted by reset mid-run produce no further wr_en or done; the downstream MAC carries are cleared by the same reset.
REQ-034 SHALL require start=1 after release for a new operation.

Configuration
REQ-035 With macro MUL_ACC_SEQ_STALL_EN defined, SHALL provide port stall.
REQ-036 While stall=1, SHALL force MulAccEn=0 and wr_en=0, and hold state, counters and the tag register unchanged; rd_idx and wr_idx SHALL hold.
REQ-037 With stall=1 in CARRY, SHALL delay the carry write and done until stall=0.
REQ-038 Without the macro, SHALL omit port stall and behave exactly as with stall=0 permanently.

Verification
REQ-039 LIMBS=4, LAT=6, start at cycle 0 -> MulAccEn=1 in cycles 1-10; rd_idx 0,1,2,3 in cycles 1-4; ArithRegOp=1 in cycles 1-6; wr_en in cycles 7-10 with wr_idx 0-3; ArithOp=0 in cycle 7 and 1 in cycles 8-10; cycle 11 has wr_en=1, wr_idx=4, wr_carry_sel=1, done=1; busy=1 in cycles 1-11.
REQ-040 start held high continuously -> operations restart every 12 cycles; start pulses during busy are ignored (exactly one done per 12 cycles).
REQ-041 nreset low at cycle 5 of an operation -> all outputs 0 at once; no wr_en or done until a new start; the next operation matches REQ-039 timing.
REQ-042 LIMBS=2, LAT=1 -> wr_en in cycles 2-3 (wr_idx 0,1) and carry write/done in cycle 4.
REQ-043 MUL_ACC_SEQ_STALL_EN, stall=1 in cycles 3-5 and in cycle 14 -> every event of REQ-039 after cycle 2 shifts by 3 cycles and done lands in cycle 15; with stall=1 in cycle 14, done shifts to cycle 15 only once; outputs do not change during stall.

Source files
------------

// File: rtl/mul_acc_seq_if.sv
// Control bus between the row multiply-accumulate sequencer and its MAC datapath.
// The stall input exists only when MUL_ACC_SEQ_STALL_EN is defined.
interface mul_acc_seq_if #(
    parameter int IDX_W = 4
);
    logic             start;
`ifdef MUL_ACC_SEQ_STALL_EN
    logic             stall;
`endif
    logic             MulAccEn;
    logic             ArithOp;
    logic             ArithRegOp;
    logic [IDX_W-1:0] rd_idx;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_carry_sel;
    logic             busy;
    logic             done;

    modport master (
`ifdef MUL_ACC_SEQ_STALL_EN
        input  stall,
`endif
        input  start,
        output MulAccEn, ArithOp, ArithRegOp, rd_idx, wr_en, wr_idx,
        output wr_carry_sel, busy, done
    );

    modport slave (
`ifdef MUL_ACC_SEQ_STALL_EN
        output stall,
`endif
        output start,
        input  MulAccEn, ArithOp, ArithRegOp, rd_idx, wr_en, wr_idx,
        input  wr_carry_sel, busy, done
    );
endinterface

// File: rtl/mul_acc_seq.sv
// Sequencer for one row operation R = A*b + C over LIMBS limbs through a LAT-deep MAC pipeline.
// Optional freeze input enabled by MUL_ACC_SEQ_STALL_EN.
module mul_acc_seq #(
    parameter int CP_D_WIDTH = 72,
    parameter int LIMBS      = 4,
    parameter int LAT        = 6,
    parameter int IDX_W      = 4
) (
    input logic           clock,
    input logic           nreset,
    mul_acc_seq_if.master bus
);
    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] CARRY = 2'd3;

    localparam logic [IDX_W-1:0] LIMBS_I = IDX_W'(LIMBS);
    localparam logic [IDX_W-1:0] LAST_I  = IDX_W'(LIMBS - 1);
    localparam logic [DW-1:0]    LAST_D  = DW'(LAT - 1);

    // Datapath width only travels with the instance; reject nonsense configurations early.
    if (CP_D_WIDTH < 1 || LIMBS < 2 || LIMBS > (1 << IDX_W) - 1 || LAT < 1) begin : g_param_chk
        $error("mul_acc_seq: illegal parameter set");
    end

    logic [1:0]       state;
    logic [IDX_W-1:0] iss_cnt;
    logic [DW-1:0]    drn_cnt;
    logic [IDX_W-1:0] wr_cnt;
    logic [LAT-1:0]   tag_v;
    logic [LAT-1:0]   tag_f;
    logic             stl;
    logic             mac_en;
    logic             out_v;
    logic             out_f;
    logic             carry_wr;

`ifdef MUL_ACC_SEQ_STALL_EN
    assign stl = bus.stall;
`else
    assign stl = 1'b0;
`endif

    assign mac_en   = (state == ISSUE || state == DRAIN) && !stl;
    assign carry_wr = (state == CARRY) && !stl;
    assign out_v    = tag_v[LAT-1];
    assign out_f    = tag_f[LAT-1];

    assign bus.MulAccEn     = mac_en;
    assign bus.ArithRegOp   = mac_en & ~out_v;
    assign bus.ArithOp      = out_v & ~out_f;
    assign bus.rd_idx       = iss_cnt;
    assign bus.wr_en        = (mac_en & out_v) | carry_wr;
    assign bus.wr_idx       = wr_cnt;
    assign bus.wr_carry_sel = carry_wr;
    assign bus.done         = carry_wr;
    assign bus.busy         = (state != IDLE);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            iss_cnt <= '0;
            drn_cnt <= '0;
            wr_cnt  <= '0;
            tag_v   <= '0;
            tag_f   <= '0;
        end else begin
            // Tags travel in lockstep with the MAC pipeline, so they only move when it does.
            if (mac_en) begin
                tag_v[0] <= (state == ISSUE);
                tag_f[0] <= (state == ISSUE) && (iss_cnt == '0);
                for (int i = 1; i < LAT; i++) begin
                    tag_v[i] <= tag_v[i-1];
                    tag_f[i] <= tag_f[i-1];
                end
                if (out_v && wr_cnt != LIMBS_I)
                    wr_cnt <= wr_cnt + IDX_W'(1);
            end
            case (state)
                IDLE: if (bus.start) state <= ISSUE;
                ISSUE: if (!stl) begin
                    if (iss_cnt == LAST_I) begin
                        iss_cnt <= '0;
                        drn_cnt <= '0;
                        state   <= DRAIN;
                    end else begin
                        iss_cnt <= iss_cnt + IDX_W'(1);
                    end
                end
                DRAIN: if (!stl) begin
                    if (drn_cnt == LAST_D) begin
                        drn_cnt <= '0;
                        state   <= CARRY;
                    end else begin
                        drn_cnt <= drn_cnt + DW'(1);
                    end
                end
                CARRY: if (!stl) begin
                    wr_cnt <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_acc_seq.sv
// Scoreboard bench: stimulus queues expected result writes, per-DUT monitors pop them on wr_en.
// Covers the default build and, when MUL_ACC_SEQ_STALL_EN is defined, the stall schedule.
module tb_mul_acc_seq;
    typedef struct {
        int cyc;
        int idx;
        int aop;
        int csel;
        int dn;
    } wr_t;

    logic clock = 1'b0;
    logic nreset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    wr_t  q1[$];
    wr_t  q2[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mul_acc_seq_if #(.IDX_W(4)) if1 ();
    mul_acc_seq_if #(.IDX_W(4)) if2 ();

    mul_acc_seq #(.CP_D_WIDTH(72), .LIMBS(4), .LAT(6), .IDX_W(4)) dut1 (
        .clock(clock), .nreset(nreset), .bus(if1.master));
    mul_acc_seq #(.CP_D_WIDTH(72), .LIMBS(2), .LAT(1), .IDX_W(4)) dut2 (
        .clock(clock), .nreset(nreset), .bus(if2.master));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_op(input bit which, input int c0, input int limbs, input int lat);
        wr_t e;
        for (int k = 0; k <= limbs; k++) begin
            e.cyc  = (k < limbs) ? c0 + 1 + lat + k : c0 + limbs + lat + 1;
            e.idx  = k;
            e.aop  = (k != 0 && k < limbs) ? 1 : 0;
            e.csel = (k == limbs) ? 1 : 0;
            e.dn   = (k == limbs) ? 1 : 0;
            if (which) q2.push_back(e);
            else       q1.push_back(e);
        end
    endtask

    always @(negedge clock) begin : mon1
        wr_t e;
        if (nreset && if1.wr_en) begin
            if (q1.size() == 0) chk("dut1_unexpected_wr", cyc, -1);
            else begin
                e = q1.pop_front();
                chk("dut1_wr_cycle", cyc, e.cyc);
                chk("dut1_wr_idx", int'(if1.wr_idx), e.idx);
                chk("dut1_arith_op", int'(if1.ArithOp), e.aop);
                chk("dut1_carry_sel", int'(if1.wr_carry_sel), e.csel);
                chk("dut1_done", int'(if1.done), e.dn);
            end
        end
        if (nreset && if1.done && !if1.wr_en) chk("dut1_done_without_wr", 1, 0);
    end

    always @(negedge clock) begin : mon2
        wr_t e;
        if (nreset && if2.wr_en) begin
            if (q2.size() == 0) chk("dut2_unexpected_wr", cyc, -1);
            else begin
                e = q2.pop_front();
                chk("dut2_wr_cycle", cyc, e.cyc);
                chk("dut2_wr_idx", int'(if2.wr_idx), e.idx);
                chk("dut2_arith_op", int'(if2.ArithOp), e.aop);
                chk("dut2_carry_sel", int'(if2.wr_carry_sel), e.csel);
                chk("dut2_done", int'(if2.done), e.dn);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mac_en"}, int'(if1.MulAccEn), 0);
        chk({tag, "_arith_op"}, int'(if1.ArithOp), 0);
        chk({tag, "_arith_reg_op"}, int'(if1.ArithRegOp), 0);
        chk({tag, "_rd_idx"}, int'(if1.rd_idx), 0);
        chk({tag, "_wr_en"}, int'(if1.wr_en), 0);
        chk({tag, "_wr_idx"}, int'(if1.wr_idx), 0);
        chk({tag, "_carry_sel"}, int'(if1.wr_carry_sel), 0);
        chk({tag, "_busy"}, int'(if1.busy), 0);
        chk({tag, "_done"}, int'(if1.done), 0);
    endtask

    // Single LIMBS=4/LAT=6 operation with a start pulse in cycle 3 that must be ignored.
    task automatic run_std();
        int c0;
        tick();
        c0 = cyc;
        if1.start = 1'b1;
        push_op(1'b0, c0, 4, 6);
        for (int n = 1; n <= 12; n++) begin
            tick();
            if1.start = (n == 3);
            #3;
            chk($sformatf("mac_en_c%0d", n), int'(if1.MulAccEn), (n <= 10) ? 1 : 0);
            chk($sformatf("rd_idx_c%0d", n), int'(if1.rd_idx), (n <= 4) ? n - 1 : 0);
            chk($sformatf("arith_reg_op_c%0d", n), int'(if1.ArithRegOp), (n <= 6) ? 1 : 0);
            chk($sformatf("busy_c%0d", n), int'(if1.busy), (n <= 11) ? 1 : 0);
        end
        if1.start = 1'b0;
    endtask

    initial begin
        int c0;
        if1.start = 1'b0;
        if2.start = 1'b0;
`ifdef MUL_ACC_SEQ_STALL_EN
        if1.stall = 1'b0;
        if2.stall = 1'b0;
`endif
        #3;
        chk_all_zero("reset");
        tick();
        tick();
        nreset = 1'b1;
        tick();

        run_std();
        tick();

        // Reset in cycle 5 of an operation: everything drops at once, nothing follows.
        tick();
        c0 = cyc;
        if1.start = 1'b1;
        push_op(1'b0, c0, 4, 6);
        for (int n = 1; n <= 5; n++) begin
            tick();
            if1.start = 1'b0;
        end
        #1 nreset = 1'b0;
        #1 chk_all_zero("midrst");
        q1.delete();
        tick();
        nreset = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            #3 chk("post_rst_busy", int'(if1.busy), 0);
        end
        run_std();
        tick();

        // start held high: back-to-back operations every 12 cycles.
        tick();
        c0 = cyc;
        if1.start = 1'b1;
        push_op(1'b0, c0, 4, 6);
        push_op(1'b0, c0 + 12, 4, 6);
        push_op(1'b0, c0 + 24, 4, 6);
        for (int n = 1; n <= 35; n++) begin
            tick();
            #3;
            if (n % 12 == 0) chk($sformatf("cont_idle_c%0d", n), int'(if1.busy), 0);
        end
        tick();
        if1.start = 1'b0;
        #3 chk("cont_end_busy", int'(if1.busy), 0);
        tick();

        // Minimum configuration LIMBS=2, LAT=1.
        tick();
        c0 = cyc;
        if2.start = 1'b1;
        push_op(1'b1, c0, 2, 1);
        tick();
        if2.start = 1'b0;
        #3 chk("dut2_mac_en_c1", int'(if2.MulAccEn), 1);
        for (int n = 2; n <= 6; n++) tick();

`ifdef MUL_ACC_SEQ_STALL_EN
        // Stall in cycles 3-5 and 14: writes move to 10-13, carry/done to 15.
        tick();
        c0 = cyc;
        if1.start = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            wr_t e;
            e.cyc  = (k < 4) ? c0 + 10 + k : c0 + 15;
            e.idx  = k;
            e.aop  = (k != 0 && k < 4) ? 1 : 0;
            e.csel = (k == 4) ? 1 : 0;
            e.dn   = (k == 4) ? 1 : 0;
            q1.push_back(e);
        end
        for (int n = 1; n <= 17; n++) begin
            tick();
            if1.start = 1'b0;
            if1.stall = ((n >= 3 && n <= 5) || n == 14);
            #3;
            if (if1.stall) begin
                chk($sformatf("stall_mac_en_c%0d", n), int'(if1.MulAccEn), 0);
                chk($sformatf("stall_busy_c%0d", n), int'(if1.busy), 1);
            end
            if (n == 7) chk("stall_rd_idx_c7", int'(if1.rd_idx), 3);
        end
        if1.stall = 1'b0;
`endif

        tick();
        tick();
        tick();
        chk("dut1_queue_drained", q1.size(), 0);
        chk("dut2_queue_drained", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
